// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier
// Iterative radix-4 (modified Booth) multiplier with a start/busy/done handshake.
// Each RUN cycle retires two multiplier bits; signed or unsigned per request.
// Optional feature macro: BOOTH_ZERO_BYPASS_EN (a zero operand finishes at once).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one Booth digit per cycle; busy high
// DONE  | single-cycle done pulse, result valid; start is accepted here
module booth_radix4_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);
    // Operands carry two extra bits so unsigned values get a positive top digit.
    localparam int EW   = WIDTH + 2;
    localparam int HW   = EW + 1;
    localparam int ACCW = HW + EW;
    localparam int N    = WIDTH / 2 + 1;
    localparam int CW   = $clog2(N);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ACCW-1:0]     r_acc;
    logic [EW-1:0]       r_m;
    logic                r_prev;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_result;

    logic [EW-1:0]       w_a_ext;
    logic [EW-1:0]       w_b_ext;
    logic [HW-1:0]       w_dec;
    logic [HW-1:0]       w_hi_sum;
    logic [ACCW-1:0]     w_sum;
    logic [ACCW-1:0]     w_acc_next;
    logic                w_accept;
    logic                w_last;
    logic                w_zero;

    assign w_a_ext  = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign w_b_ext  = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_cnt == CW'(N - 1));

`ifdef BOOTH_ZERO_BYPASS_EN
    assign w_zero = (a == '0) || (b == '0);
`else
    assign w_zero = 1'b0;
`endif

    // Booth digit decode of {b[2i+1], b[2i], b[2i-1]} into the addend for the upper half.
    always_comb begin
        w_dec = '0;
        case ({r_acc[1:0], r_prev})
            3'b001, 3'b010: w_dec = {r_m[EW-1], r_m};
            3'b011:         w_dec = {r_m, 1'b0};
            3'b100:         w_dec = -{r_m, 1'b0};
            3'b101, 3'b110: w_dec = -{r_m[EW-1], r_m};
            default:        w_dec = '0;
        endcase
    end

    // Add into the upper half, then arithmetic shift of the whole accumulator by two.
    always_comb begin
        w_hi_sum   = r_acc[ACCW-1:EW] + w_dec;
        w_sum      = {w_hi_sum, r_acc[EW-1:0]};
        w_acc_next = {{2{w_sum[ACCW-1]}}, w_sum[ACCW-1:2]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_zero ? DONE : RUN;
            RUN:     if (w_last)   w_state_next = DONE;
            DONE:    w_state_next = w_accept ? (w_zero ? DONE : RUN) : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    assign result = r_result;

    // Datapath: latch operands on acceptance, one Booth step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_m      <= '0;
            r_prev   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_acc  <= {{HW{1'b0}}, w_b_ext};
            r_m    <= w_a_ext;
            r_prev <= 1'b0;
            r_cnt  <= '0;
            if (w_zero) r_result <= '0;
        end else if (r_state == RUN) begin
            r_acc  <= w_acc_next;
            r_prev <= r_acc[1];
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) r_result <= w_acc_next[2*WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for booth_radix4_multiplier (WIDTH=16 and WIDTH=8 instances).
module tb_booth_radix4_multiplier;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sm;
    logic [15:0] a, b;
    logic        busy, done;
    logic [31:0] result;
    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] result8;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic [31:0] q16[$];
    logic [15:0] q8[$];

    always #5 clk = ~clk;

    booth_radix4_multiplier #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .a(a), .b(b),
        .busy(busy), .done(done), .result(result));

    booth_radix4_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8));

    function automatic logic [31:0] model16(input logic s, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] xe, ye;
        xe = s ? {{16{x[15]}}, x} : {16'h0, x};
        ye = s ? {{16{y[15]}}, y} : {16'h0, y};
        return xe * ye;
    endfunction

    function automatic logic [15:0] model8(input logic s, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] xe, ye;
        xe = s ? {{8{x[7]}}, x} : {8'h0, x};
        ye = s ? {{8{y[7]}}, y} : {8'h0, y};
        return xe * ye;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after the accepting edge; counts cycles to done.
    task automatic wait_done16(input string tag);
        int          cyc = 1;
        logic [31:0] exp;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd10);
        exp = (q16.size() > 0) ? q16.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_res"}, 64'(result), 64'(exp));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic issue16(input logic s, input logic [15:0] x, input logic [15:0] y);
        sm = s; a = x; b = y; start = 1'b1;
        q16.push_back(model16(s, x, y));
    endtask

    task automatic op16(input string tag, input logic s, input logic [15:0] x, input logic [15:0] y);
        issue16(s, x, y);
        @(negedge clk);
        start = 1'b0;
        wait_done16(tag);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y);
        int          cyc = 1;
        logic [15:0] exp;
        sm8 = s; a8 = x; b8 = y; start8 = 1'b1;
        q8.push_back(model8(s, x, y));
        @(negedge clk);
        start8 = 1'b0;
        while (done8 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("w8_lat", 64'(cyc), 64'd6);
        exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        check($sformatf("w8_s%0d_%0h_%0h", s, x, y), 64'(result8), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        logic       saw_done;
        logic [7:0] cv [5];
        cv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        rst_n = 1'b0; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op16("neg_sq", 1'b1, 16'h8000, 16'h8000);
        op16("u_ffff", 1'b0, 16'hFFFF, 16'hFFFF);
        op16("s_m1x2", 1'b1, 16'hFFFF, 16'h0002);
        op16("s_max_min", 1'b1, 16'h7FFF, 16'h8000);
        op16("u_mix", 1'b0, 16'hA5C3, 16'h1F0E);
        op16("zero_a", 1'b0, 16'h0000, 16'h1234);

        // Request while busy is ignored.
        issue16(1'b0, 16'd3, 16'd5);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("ign_busy_c%0d", c), 64'(busy), 64'd1);
            if (c == 3) begin start = 1'b1; sm = 1'b1; a = 16'd7; b = 16'd7; end
            if (c == 4) start = 1'b0;
            @(negedge clk);
        end
        check("ign_done", 64'(done), 64'd1);
        check("ign_res", 64'(result), 64'(q16.pop_front()));
        @(negedge clk);
        check("ign_no_rerun_busy", 64'(busy), 64'd0);
        check("ign_no_rerun_done", 64'(done), 64'd0);

        // Asynchronous reset mid-run.
        issue16(1'b1, 16'd100, 16'd100);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        void'(q16.pop_front());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("arst_no_done", 64'(saw_done), 64'd0);
        op16("post_rst", 1'b1, 16'hFFF9, 16'd6);
        check("post_rst_const", 64'(result), 64'hFFFF_FFD6);

        // Start held high: back-to-back, N+1 cycles apart.
        issue16(1'b1, 16'd2, 16'd3);
        @(negedge clk);
        issue16(1'b1, 16'hFFFF, 16'hFFFF);
        wait_done16("b2b_1");
        @(negedge clk);
        start = 1'b0;
        wait_done16("b2b_2");
        check("b2b_2_const", 64'(result), 64'd1);
        @(negedge clk);

        // WIDTH=8: corner cross products and random pairs in both modes.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    op8(s[0], cv[i], cv[j]);
        for (int k = 0; k < 150; k++)
            op8(k[0], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
